// File: rtl/irrigation_controller.sv
// Irrigation controller: synchronizes the switches and sensors, debounces the
// three tank probes, drives the tank inlet valve with hysteresis and sequences
// dripper/sprinkler irrigation cycles. Every output is registered.
module irrigation_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned DRIP_CYCLES     = 1000,
  parameter int unsigned SPRINKLE_CYCLES = 500,
  parameter int unsigned COOLDOWN_CYCLES = 200,
  parameter int unsigned COUNT_WIDTH     = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic system_enable,
  input  logic mode_select,
  input  logic soil_dry,
  input  logic rain_detected,
  input  logic low_probe_raw,
  input  logic mid_probe_raw,
  input  logic high_probe_raw,
  output logic low_water_level,
  output logic mid_water_level,
  output logic high_water_level,
  output logic conflicting_water_sensor,
  output logic irrigation_mode_on,
  output logic dripper,
  output logic splinker,
  output logic water_inlet_valve
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_DRIP     = 3'd1;
  localparam logic [2:0] ST_SPRINKLE = 3'd2;
  localparam logic [2:0] ST_COOLDOWN = 3'd3;
  localparam logic [2:0] ST_FAULT    = 3'd4;

  // Raw input bundle: [2:0] probes {high, mid, low}, then enable, mode, dry, rain.
  logic [6:0] raw_w;
  logic [6:0] sync1_q;
  logic [6:0] sync2_q;

  assign raw_w = {rain_detected, soil_dry, mode_select, system_enable,
                  high_probe_raw, mid_probe_raw, low_probe_raw};

  logic [2:0] probe_sync_w;
  logic       enable_s, mode_s, dry_s, rain_s;

  assign probe_sync_w = sync2_q[2:0];
  assign enable_s     = sync2_q[3];
  assign mode_s       = sync2_q[4];
  assign dry_s        = sync2_q[5];
  assign rain_s       = sync2_q[6];

  // Two-flop synchronizer for every asynchronous board input.
  // NOTE: sequential state always uses <=, so both stages sample the pre-edge values
  // and the chain really is two flops deep rather than collapsing into one.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_w;
      sync2_q <= sync1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Probe debounce: a level only moves after DEBOUNCE_CYCLES consecutive
  // differing samples; any agreeing sample restarts the count.
  // ---------------------------------------------------------------------------
  logic [2:0]           level_q, level_d;
  logic [2:0][DB_W-1:0] db_cnt_q, db_cnt_d;

  // Next debounced level and run-length counter per probe.
  // NOTE: every variable gets its default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    level_d  = level_q;
    db_cnt_d = db_cnt_q;
    for (int p = 0; p < 3; p++) begin
      if (probe_sync_w[p] == level_q[p]) begin
        db_cnt_d[p] = '0;
      end else if (db_cnt_q[p] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d[p]  = probe_sync_w[p];
        db_cnt_d[p] = '0;
      end else begin
        db_cnt_d[p] = db_cnt_q[p] + DB_W'(1);
      end
    end
  end

  // Debounce state registers; the counters are a handful of flops, reset with the rest.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      level_q  <= '0;
      db_cnt_q <= '0;
    end else begin
      level_q  <= level_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  logic low_l, mid_l, high_l;
  assign low_l  = level_q[0];
  assign mid_l  = level_q[1];
  assign high_l = level_q[2];

  // A wetter probe reading water while a drier one does not is physically impossible.
  logic conflict_q, conflict_d;
  assign conflict_d = (high_l & ~mid_l) | (mid_l & ~low_l);

  // ---------------------------------------------------------------------------
  // Irrigation FSM with one shared timer, cleared on every state change.
  // ---------------------------------------------------------------------------
  logic [2:0]             state_q, state_d;
  logic [COUNT_WIDTH-1:0] timer_q, timer_d;
  logic                   stop_w;
  logic                   ready_w;

  assign stop_w  = ~enable_s | ~dry_s | rain_s | ~low_l;
  assign ready_w = ~stop_w;

  // Next-state logic; a probe conflict overrides every other transition.
  always_comb begin
    state_d = state_q;
    if (conflict_q) begin
      state_d = ST_FAULT;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // mode_select only matters here, at the moment a cycle starts.
          if (ready_w && !mode_s)      state_d = ST_DRIP;
          else if (ready_w && mid_l)   state_d = ST_SPRINKLE;
        end
        ST_DRIP: begin
          if (stop_w || timer_q == COUNT_WIDTH'(DRIP_CYCLES - 1))
            state_d = ST_COOLDOWN;
        end
        ST_SPRINKLE: begin
          if (stop_w || !mid_l || timer_q == COUNT_WIDTH'(SPRINKLE_CYCLES - 1))
            state_d = ST_COOLDOWN;
        end
        ST_COOLDOWN: begin
          if (timer_q == COUNT_WIDTH'(COOLDOWN_CYCLES - 1)) state_d = ST_IDLE;
        end
        ST_FAULT: begin
          // Operator acknowledges a cleared fault by switching the system off.
          if (!enable_s) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    timer_d = (state_d != state_q) ? '0 : timer_q + COUNT_WIDTH'(1);
  end

  // Inlet valve hysteresis: fill from empty until full, never while faulted.
  logic valve_q, valve_d;
  always_comb begin
    valve_d = valve_q;
    if (state_d == ST_FAULT || high_l || conflict_q) valve_d = 1'b0;
    else if (!low_l)                                 valve_d = 1'b1;
  end

  logic dripper_q, splinker_q, mode_on_q;

  // State, timer and actuator registers; actuators decode the next state so they
  // switch on the same edge the state does.
  // NOTE: the reset is asynchronous so every actuator drops the instant reset_n
  // falls, without waiting for a clock edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      conflict_q <= 1'b0;
      valve_q    <= 1'b0;
      dripper_q  <= 1'b0;
      splinker_q <= 1'b0;
      mode_on_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      conflict_q <= conflict_d;
      valve_q    <= valve_d;
      dripper_q  <= (state_d == ST_DRIP);
      splinker_q <= (state_d == ST_SPRINKLE);
      mode_on_q  <= (state_d == ST_DRIP) || (state_d == ST_SPRINKLE);
    end
  end

  assign low_water_level          = level_q[0];
  assign mid_water_level          = level_q[1];
  assign high_water_level         = level_q[2];
  assign conflicting_water_sensor = conflict_q;
  assign water_inlet_valve        = valve_q;
  assign dripper                  = dripper_q;
  assign splinker                 = splinker_q;
  assign irrigation_mode_on       = mode_on_q;

endmodule

// File: tb/tb_irrigation_controller.sv
// Testbench for irrigation_controller: directed scenarios plus randomized input
// segments, compared every cycle against a behavioural model via a scoreboard queue.
module tb_irrigation_controller;

  localparam int DB   = 4;
  localparam int DRIP = 10;
  localparam int SPR  = 6;
  localparam int COOL = 3;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic system_enable = 1'b0, mode_select = 1'b0, soil_dry = 1'b0, rain_detected = 1'b0;
  logic low_probe_raw = 1'b0, mid_probe_raw = 1'b0, high_probe_raw = 1'b0;
  logic low_water_level, mid_water_level, high_water_level;
  logic conflicting_water_sensor, irrigation_mode_on, dripper, splinker, water_inlet_valve;

  always #5 clock = ~clock;

  irrigation_controller #(
    .DEBOUNCE_CYCLES(DB), .DRIP_CYCLES(DRIP), .SPRINKLE_CYCLES(SPR),
    .COOLDOWN_CYCLES(COOL), .COUNT_WIDTH(16)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .system_enable(system_enable), .mode_select(mode_select),
    .soil_dry(soil_dry), .rain_detected(rain_detected),
    .low_probe_raw(low_probe_raw), .mid_probe_raw(mid_probe_raw),
    .high_probe_raw(high_probe_raw),
    .low_water_level(low_water_level), .mid_water_level(mid_water_level),
    .high_water_level(high_water_level),
    .conflicting_water_sensor(conflicting_water_sensor),
    .irrigation_mode_on(irrigation_mode_on), .dripper(dripper),
    .splinker(splinker), .water_inlet_valve(water_inlet_valve)
  );

  logic [7:0] dut_vec;
  assign dut_vec = {low_water_level, mid_water_level, high_water_level,
                    conflicting_water_sensor, irrigation_mode_on, dripper,
                    splinker, water_inlet_valve};

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got {lo,mi,hi,conf,on,drip,spr,valve}=%b expected %b",
               name, cyc, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. Inputs reach the logic two samples late; a probe level
  // flips once the last DB synchronized samples all disagree with it; the
  // irrigation phase counts down the cycles it has left.
  // Raw vector bits: [0] low [1] mid [2] high [3] en [4] mode [5] dry [6] rain.
  // ---------------------------------------------------------------------------
  typedef enum int {M_IDLE, M_DRIP, M_SPRK, M_COOL, M_FAULT} mst_t;

  logic [6:0] delay_q[$];
  logic [2:0] win[$];
  logic [2:0] m_lvl;
  logic       m_conf, m_valve;
  mst_t       m_st;
  int         m_left;
  logic [7:0] exp_q[$];

  function automatic void model_reset();
    delay_q = '{7'd0, 7'd0};
    win.delete();
    m_lvl   = 3'b000;
    m_conf  = 1'b0;
    m_valve = 1'b0;
    m_st    = M_IDLE;
    m_left  = 0;
  endfunction

  function automatic logic [7:0] model_step(input logic [6:0] raw);
    logic [6:0] syn;
    logic [2:0] lvl_n;
    logic       conf_n, valve_n, stop, all_diff;
    mst_t       st_n;
    int         left_n;
    syn = delay_q.pop_front();
    delay_q.push_back(raw);
    win.push_back(syn[2:0]);
    if (win.size() > DB) void'(win.pop_front());

    lvl_n = m_lvl;
    for (int p = 0; p < 3; p++) begin
      all_diff = (win.size() == DB);
      foreach (win[k]) if (win[k][p] == m_lvl[p]) all_diff = 1'b0;
      if (all_diff) lvl_n[p] = ~m_lvl[p];
    end

    conf_n = (m_lvl[2] && !m_lvl[1]) || (m_lvl[1] && !m_lvl[0]);
    stop   = !syn[3] || !syn[5] || syn[6] || !m_lvl[0];

    st_n   = m_st;
    left_n = m_left - 1;
    if (m_conf) st_n = M_FAULT;
    else begin
      case (m_st)
        M_IDLE: if (!stop) begin
          if (!syn[4])       begin st_n = M_DRIP; left_n = DRIP; end
          else if (m_lvl[1]) begin st_n = M_SPRK; left_n = SPR;  end
        end
        M_DRIP:  if (m_left == 1 || stop)              begin st_n = M_COOL; left_n = COOL; end
        M_SPRK:  if (m_left == 1 || stop || !m_lvl[1]) begin st_n = M_COOL; left_n = COOL; end
        M_COOL:  if (m_left == 1) st_n = M_IDLE;
        M_FAULT: if (!syn[3])     st_n = M_IDLE;
        default: st_n = M_IDLE;
      endcase
    end

    valve_n = m_valve;
    if (st_n == M_FAULT || m_lvl[2] || m_conf) valve_n = 1'b0;
    else if (!m_lvl[0])                        valve_n = 1'b1;

    m_lvl = lvl_n; m_conf = conf_n; m_valve = valve_n; m_st = st_n; m_left = left_n;
    return {m_lvl[0], m_lvl[1], m_lvl[2], m_conf,
            (m_st == M_DRIP || m_st == M_SPRK), m_st == M_DRIP, m_st == M_SPRK, m_valve};
  endfunction

  // Stimulus: drive on the falling edge and push what the next rising edge must produce.
  task automatic step(input logic [6:0] raw);
    @(negedge clock);
    {rain_detected, soil_dry, mode_select, system_enable,
     high_probe_raw, mid_probe_raw, low_probe_raw} = raw;
    exp_q.push_back(model_step(raw));
  endtask

  task automatic hold(input logic [6:0] raw, input int n);
    repeat (n) step(raw);
  endtask

  function automatic logic [6:0] mk(input bit en, input bit mode, input bit dry,
                                    input bit rain, input logic [2:0] hml);
    return {rain, dry, mode, en, hml};
  endfunction

  // Monitor: pop and compare one expectation per clock while out of reset.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (reset_n) begin
        cyc++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL outputs cycle %0d: got %b expected no entry queued", cyc, dut_vec);
        end else begin
          check("outputs", dut_vec, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [2:0] probes;
    model_reset();
    repeat (3) @(posedge clock);
    #1 check("reset", dut_vec, 8'h00);
    #1 reset_n = 1'b1;

    // Probe glitch of 3 cycles, then a stable rise.
    hold(mk(0, 0, 0, 0, 3'b000), 10);
    hold(mk(0, 0, 0, 0, 3'b001), 3);
    hold(mk(0, 0, 0, 0, 3'b000), 6);
    hold(mk(0, 0, 0, 0, 3'b001), 12);

    // Drip cycle, cooldown, re-entry.
    hold(mk(1, 0, 1, 0, 3'b001), 40);
    // Early stop by rain mid-drip.
    hold(mk(1, 0, 1, 0, 3'b001), 5);
    hold(mk(1, 0, 1, 1, 3'b001), 10);

    // Sprinkle refused without mid, then granted; mode toggled during it.
    hold(mk(1, 1, 1, 0, 3'b001), 15);
    hold(mk(1, 1, 1, 0, 3'b011), 9);
    hold(mk(1, 0, 1, 0, 3'b011), 3);
    hold(mk(1, 1, 1, 0, 3'b011), 20);

    // Conflict during sprinkle, cleared probes, then acknowledge.
    hold(mk(1, 1, 1, 0, 3'b011), 9);
    hold(mk(1, 1, 1, 0, 3'b101), 15);
    hold(mk(1, 1, 1, 0, 3'b001), 15);
    hold(mk(0, 1, 1, 0, 3'b001), 10);

    // Refill hysteresis.
    hold(mk(0, 0, 0, 0, 3'b000), 10);
    hold(mk(0, 0, 0, 0, 3'b001), 10);
    hold(mk(0, 0, 0, 0, 3'b011), 10);
    hold(mk(0, 0, 0, 0, 3'b111), 10);
    hold(mk(0, 0, 0, 0, 3'b101), 10);
    hold(mk(0, 0, 0, 0, 3'b001), 12);

    // Asynchronous reset while dripping.
    for (int i = 0; i < 60 && m_st != M_DRIP; i++) step(mk(1, 0, 1, 0, 3'b001));
    step(mk(1, 0, 1, 0, 3'b001));
    @(posedge clock);
    #2;
    if (m_st == M_DRIP) begin
      reset_n = 1'b0;
      #1 check("async_reset", dut_vec, 8'h00);
      model_reset();
      @(posedge clock);
      #2 reset_n = 1'b1;
    end else begin
      checks++;
      errors++;
      $display("FAIL async_reset: got no DRIP phase within 60 cycles required DRIP");
    end

    // Randomized segments.
    for (int s = 0; s < 250; s++) begin
      case ($urandom_range(0, 7))
        0: probes = 3'($urandom_range(0, 7));
        1, 2: probes = 3'b000;
        3, 4: probes = 3'b001;
        5: probes = 3'b011;
        default: probes = 3'b111;
      endcase
      hold(mk($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 4) != 0, $urandom_range(0, 5) == 0, probes),
           $urandom_range(1, 12));
    end

    @(posedge clock);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
